// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold alarm qualifier.
// Holds the FSM encoding, default run lengths and the run-counter width.
package threshold_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ALARM    = 2'd2,
        ST_CLEARING = 2'd3
    } state_e;

    localparam int DEF_ASSERT_CYCLES = 4;
    localparam int DEF_CLEAR_CYCLES  = 4;
    localparam int RUN_W             = 8;

    // A comparator sample is only trusted when exactly one flag is set.
    function automatic logic is_onehot3(input logic a, input logic b, input logic c);
        return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
    endfunction

endpackage

// File: rtl/threshold_monitor_if.sv
// Comparator-flag inputs and qualified alarm outputs of the threshold monitor.
// master drives flags/controls and observes results; slave is the monitor itself.
interface threshold_monitor_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 en;
    logic                 greater;
    logic                 lesser;
    logic                 equal;
    logic                 clr_count;
    logic                 alarm;
    logic                 rise_pulse;
    logic                 fall_pulse;
    logic [CNT_WIDTH-1:0] event_count;
    logic                 flag_err;
    logic [1:0]           state;

    modport master (
        output en, greater, lesser, equal, clr_count,
        input  alarm, rise_pulse, fall_pulse, event_count, flag_err, state
    );

    modport slave (
        input  en, greater, lesser, equal, clr_count,
        output alarm, rise_pulse, fall_pulse, event_count, flag_err, state
    );
endinterface

// File: rtl/threshold_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Latency: count updates on the edge sampling inc/clr; no backpressure.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/threshold_monitor.sv
// Debounced, hysteretic alarm qualifier for per-cycle comparator flags.
// Latency: all outputs registered, one edge after the deciding sample; no backpressure.
module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int CNT_WIDTH     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    threshold_monitor_if.slave mon
);
    localparam logic [RUN_W-1:0] ASSERT_LAST = RUN_W'(ASSERT_CYCLES - 1);
    localparam logic [RUN_W-1:0] CLEAR_LAST  = RUN_W'(CLEAR_CYCLES - 1);

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               err_q, err_d;
    logic               smp_valid;
    logic               smp_gt;
    logic               smp_lt;
    logic [CNT_WIDTH-1:0] event_count;

    // Malformed samples collapse to "equal" so they never extend a streak.
    assign smp_valid = is_onehot3(mon.greater, mon.lesser, mon.equal);
    assign smp_gt    = smp_valid & mon.greater;
    assign smp_lt    = smp_valid & mon.lesser;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!mon.en) begin
            state_d = ST_IDLE;
            run_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (smp_gt) begin
                        if (ASSERT_CYCLES == 1) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            state_d = ST_ARMING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (smp_gt) begin
                        if (run_q == ASSERT_LAST) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (smp_lt) begin
                        if (CLEAR_CYCLES == 1) begin
                            state_d = ST_IDLE;
                            fall_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            state_d = ST_CLEARING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_CLEARING: begin
                    if (smp_lt) begin
                        if (run_q == CLEAR_LAST) begin
                            state_d = ST_IDLE;
                            fall_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        state_d = ST_ALARM;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end

        alarm_d = (state_d == ST_ALARM) || (state_d == ST_CLEARING);
        err_d   = mon.clr_count ? 1'b0 : (err_q | ~smp_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_event_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rise_d),
        .clr   (mon.clr_count),
        .count (event_count)
    );

    assign mon.alarm       = alarm_q;
    assign mon.rise_pulse  = rise_q;
    assign mon.fall_pulse  = fall_q;
    assign mon.event_count = event_count;
    assign mon.flag_err    = err_q;
    assign mon.state       = state_q;
endmodule

// File: tb/tb_threshold_monitor.sv
// Scoreboard bench for threshold_monitor with ASSERT=4, CLEAR=3 and a 2-bit event counter.
module tb_threshold_monitor;
    import threshold_monitor_pkg::*;

    localparam int AC = 4;
    localparam int CC = 3;
    localparam int CW = 2;

    typedef struct packed {
        logic [1:0]    st;
        logic          alarm;
        logic          rise;
        logic          fall;
        logic          err;
        logic [CW-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    threshold_monitor_if #(.CNT_WIDTH(CW)) bus ();

    threshold_monitor #(
        .ASSERT_CYCLES (AC),
        .CLEAR_CYCLES  (CC),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    obs_t sb_q[$];

    int m_st, m_run, m_cnt;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.st    = bus.state;
        o.alarm = bus.alarm;
        o.rise  = bus.rise_pulse;
        o.fall  = bus.fall_pulse;
        o.err   = bus.flag_err;
        o.cnt   = bus.event_count;
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_run = 0; m_cnt = 0; m_err = 0;
    endtask

    // Called at a negedge: drive one sample, predict, then compare after the edge.
    task automatic drive(input bit en, input bit g, input bit l, input bit e, input bit clr);
        bit   valid, gt, lt, rise, fall;
        obs_t exp, got;
        bus.en = en; bus.greater = g; bus.lesser = l; bus.equal = e; bus.clr_count = clr;

        valid = (int'(g) + int'(l) + int'(e)) == 1;
        gt = valid && g;
        lt = valid && l;
        rise = 0; fall = 0;
        if (!valid) m_err = 1;
        if (!en) begin
            m_st = 0; m_run = 0;
        end else begin
            case (m_st)
                0: if (gt) begin
                       if (AC == 1) begin m_st = 2; rise = 1; end
                       else begin m_st = 1; m_run = 1; end
                   end
                1: if (gt) begin
                       m_run++;
                       if (m_run == AC) begin m_st = 2; rise = 1; m_run = 0; end
                   end else begin m_st = 0; m_run = 0; end
                2: if (lt) begin
                       if (CC == 1) begin m_st = 0; fall = 1; end
                       else begin m_st = 3; m_run = 1; end
                   end
                default: if (lt) begin
                       m_run++;
                       if (m_run == CC) begin m_st = 0; fall = 1; m_run = 0; end
                   end else begin m_st = 2; m_run = 0; end
            endcase
        end
        if (rise && m_cnt < (1 << CW) - 1) m_cnt++;
        if (clr) begin m_cnt = 0; m_err = 0; end

        exp.st = 2'(m_st); exp.alarm = (m_st >= 2); exp.rise = rise; exp.fall = fall;
        exp.err = m_err; exp.cnt = CW'(m_cnt);
        sb_q.push_back(exp);

        @(posedge clk);
        #1;
        got = observe();
        exp = sb_q.pop_front();
        check($sformatf("cyc%0d", cyc), 32'(got), 32'(exp));
        cyc++;
        @(negedge clk);
    endtask

    task automatic gt_n(input int n); repeat (n) drive(1, 1, 0, 0, 0); endtask
    task automatic lt_n(input int n); repeat (n) drive(1, 0, 1, 0, 0); endtask
    task automatic eq_n(input int n); repeat (n) drive(1, 0, 0, 1, 0); endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1; bus.greater = 0; bus.lesser = 0; bus.equal = 1; bus.clr_count = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(observe()), 32'd0);
        rst_n = 1;

        eq_n(5);
        check("idle_state", 32'(bus.state), 32'd0);
        check("idle_alarm", 32'(bus.alarm), 32'd0);

        gt_n(4);
        check("rise_pulse", 32'(bus.rise_pulse), 32'd1);
        check("rise_alarm", 32'(bus.alarm), 32'd1);
        check("rise_count", 32'(bus.event_count), 32'd1);
        eq_n(1);
        check("rise_once", 32'(bus.rise_pulse), 32'd0);

        lt_n(2); eq_n(1); lt_n(2);
        check("hyst_hold", 32'(bus.alarm), 32'd1);
        lt_n(1);
        check("fall_pulse", 32'(bus.fall_pulse), 32'd1);
        check("fall_alarm", 32'(bus.alarm), 32'd0);
        eq_n(1);
        check("fall_once", 32'(bus.fall_pulse), 32'd0);

        gt_n(3); eq_n(1);
        check("abort_alarm", 32'(bus.alarm), 32'd0);
        check("abort_state", 32'(bus.state), 32'd0);

        gt_n(4);
        drive(0, 0, 0, 1, 0);
        check("en_alarm", 32'(bus.alarm), 32'd0);
        check("en_state", 32'(bus.state), 32'd0);
        check("en_nofall", 32'(bus.fall_pulse), 32'd0);
        check("en_count", 32'(bus.event_count), 32'd2);

        gt_n(4);
        drive(1, 1, 1, 0, 0);
        check("err_set", 32'(bus.flag_err), 32'd1);
        check("err_hold", 32'(bus.state), 32'd2);
        drive(1, 0, 0, 0, 0);
        check("err_sticky", 32'(bus.flag_err), 32'd1);
        drive(1, 0, 0, 1, 1);
        check("clr_err", 32'(bus.flag_err), 32'd0);
        check("clr_count", 32'(bus.event_count), 32'd0);
        lt_n(3);

        gt_n(3);
        drive(1, 1, 0, 0, 1);
        check("clr_wins", 32'(bus.event_count), 32'd0);
        lt_n(3);

        repeat (5) begin gt_n(4); lt_n(3); end
        check("saturate", 32'(bus.event_count), 32'd3);

        gt_n(4); lt_n(1);
        check("in_clearing", 32'(bus.state), 32'd3);
        #2;
        rst_n = 0;
        #1;
        check("async_rst", 32'(observe()), 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1;
        eq_n(3);

        repeat (300) begin
            int  r;
            bit  g, l, e, en, clr;
            r = $urandom_range(0, 9);
            g = (r <= 3); l = (r >= 4 && r <= 6); e = (r == 7 || r == 8);
            if (r == 9) begin
                g = 1'($urandom_range(0, 1));
                l = 1'($urandom_range(0, 1));
                e = 1'($urandom_range(0, 1));
            end
            en  = ($urandom_range(0, 29) != 0);
            clr = ($urandom_range(0, 39) == 0);
            drive(en, g, l, e, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
